lin_decim: RTL and testbench
============================

Name: lin_decim

Overview:
- Two-channel integer-factor decimator (accumulate-and-dump boxcar average) for the L-R (mR) and L+R (pR) 18-bit signed paths.
- Counterpart of the linear interpolator: that block upsamples into the modulator rate; this block brings modulator-rate data back down to audio rate.
- Used by the demod/loopback check path and the verification bench.
- Every 2^DECIM_LOG2 accepted input samples, it emits one averaged sample per channel with a single-cycle output strobe.

Parameters:
- WIDTH, 18, sample width; two's complement signed.
- DECIM_LOG2, 2, log2 of decimation factor N (N = 4 by default); legal range 1..6.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- LD_in_en  input  1  input sample strobe; a sample is accepted on any rising edge where this is 1.
- LD_sync  input  1  block-phase restart; clears partial block.
- LD_mR_in  input  WIDTH  L-R input sample, signed.
- LD_pR_in  input  WIDTH  L+R input sample, signed.
- LD_mR_out  output  WIDTH  decimated L-R sample, signed, registered.
- LD_pR_out  output  WIDTH  decimated L+R sample, signed, registered.
- LD_out_en  output  1  one-cycle pulse marking new output data.
- LD_phase  output  DECIM_LOG2  count of samples accepted in the current block (0..N-1).

Behaviour:
- Reset (reset = 0, asynchronous): all of the following clear to 0 immediately and hold while reset is low: accumulators, phase counter, LD_mR_out, LD_pR_out, LD_out_en, LD_phase. First edge after release behaves as a normal cycle.
- Accumulators: one per channel, signed, WIDTH+DECIM_LOG2 bits. Sign-extend the input before adding. The accumulator cannot overflow (N samples of WIDTH bits fit by construction).
- Phase counter: DECIM_LOG2 bits. Increments on each accepted sample; wraps N-1 -> 0.
- States, implicit in the phase counter:
  - ACCUM (phase 0..N-2): on LD_in_en, acc <= acc + in, phase <= phase + 1.
  - DUMP (phase = N-1): on LD_in_en:
    - out <= (acc + in) >>> DECIM_LOG2 (arithmetic shift, floor rounding toward -inf), truncated to WIDTH bits. The result is always in range, so no saturation is needed.
    - acc <= 0; phase <= 0; LD_out_en <= 1 on the same edge.
- Latency: outputs and strobe are valid the cycle immediately after the edge that accepted the Nth sample (1 clock).
- LD_out_en is high for exactly one cycle per completed block. It is 0 in every other cycle, including cycles with LD_in_en = 0.
- LD_mR_out / LD_pR_out hold their last value between strobes.
- No input (LD_in_en = 0): accumulators, phase and outputs hold. Gaps of any length between samples are legal.
- LD_sync = 1 on an edge:
  - Discards the partial block and suppresses any output for it. If LD_in_en is also 1 on that edge, that sample is the first of a new block: acc <= in, phase <= 1.
  - If LD_in_en = 0: acc <= 0, phase <= 0.
  - Sync at phase N-1 together with LD_in_en produces no output.
  - Outputs keep their previous values.
- Back-to-back: LD_in_en held high continuously gives LD_out_en every N cycles, with no dead cycle between blocks.
- Both channels always share the phase counter and strobe. Channel data never crosses between channels.

Test Plan:
- Reset then N=4, LD_in_en continuous, mR = 100,200,300,400, pR = -100,-200,-300,-400 -> one cycle after the 4th sample: LD_out_en = 1 for 1 cycle, LD_mR_out = 250, LD_pR_out = -250; LD_phase sequence 0,1,2,3,0.
- Rounding: mR = -1,-1,-1,-2 (sum -5) -> LD_mR_out = -2. pR = 1,1,1,2 (sum 5) -> LD_pR_out = 1.
- Extremes: mR = 131071 ×4 -> 131071. pR = -131072 ×4 -> -131072. No wrap.
- Gapped strobe: samples 10,20,30,40 with 0–5 idle cycles between them -> single pulse, output 25. Outputs unchanged and LD_out_en = 0 during the gaps.
- LD_sync:
  - After 2 samples (phase = 2), assert LD_sync with LD_in_en = 1, sample 8. Then samples 8,8,8 follow -> LD_phase = 1 after sync; the discarded block gives no pulse; the next output is 8.
  - Sync with LD_in_en = 0 -> LD_phase = 0.
- Async reset mid-block: after 3 samples, drive reset low between clock edges -> outputs, LD_out_en and LD_phase go 0 without a clock edge. After release, 4 new samples of 7 -> output 7, with nothing carried over from before reset.

Source files
------------

// File: rtl/lin_decim.sv
// rtl/lin_decim.sv - two-channel accumulate-and-dump decimator (boxcar average by 2^DECIM_LOG2)
module lin_decim #(
  parameter int WIDTH      = 18,
  parameter int DECIM_LOG2 = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    LD_in_en,
  input  logic                    LD_sync,
  input  logic [WIDTH-1:0]        LD_mR_in,
  input  logic [WIDTH-1:0]        LD_pR_in,
  output logic [WIDTH-1:0]        LD_mR_out,
  output logic [WIDTH-1:0]        LD_pR_out,
  output logic                    LD_out_en,
  output logic [DECIM_LOG2-1:0]   LD_phase
);

  localparam int AccW = WIDTH + DECIM_LOG2;

  logic signed [AccW-1:0] mRAcc, pRAcc;
  logic signed [AccW-1:0] mRExt, pRExt;
  logic signed [AccW-1:0] mRSum, pRSum;
  logic                   lastPhase;

  assign mRExt     = {{DECIM_LOG2{LD_mR_in[WIDTH-1]}}, LD_mR_in};
  assign pRExt     = {{DECIM_LOG2{LD_pR_in[WIDTH-1]}}, LD_pR_in};
  assign mRSum     = mRAcc + mRExt;
  assign pRSum     = pRAcc + pRExt;
  assign lastPhase = (LD_phase == {DECIM_LOG2{1'b1}});

  // Taking the upper WIDTH bits of the sum is the arithmetic shift plus truncation (floor).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mRAcc     <= '0;
      pRAcc     <= '0;
      LD_phase  <= '0;
      LD_mR_out <= '0;
      LD_pR_out <= '0;
      LD_out_en <= 1'b0;
    end else begin
      LD_out_en <= 1'b0;
      if (LD_sync) begin
        if (LD_in_en) begin
          mRAcc    <= mRExt;
          pRAcc    <= pRExt;
          LD_phase <= DECIM_LOG2'(1);
        end else begin
          mRAcc    <= '0;
          pRAcc    <= '0;
          LD_phase <= '0;
        end
      end else if (LD_in_en) begin
        if (lastPhase) begin
          LD_mR_out <= mRSum[AccW-1:DECIM_LOG2];
          LD_pR_out <= pRSum[AccW-1:DECIM_LOG2];
          LD_out_en <= 1'b1;
          mRAcc     <= '0;
          pRAcc     <= '0;
          LD_phase  <= '0;
        end else begin
          mRAcc    <= mRSum;
          pRAcc    <= pRSum;
          LD_phase <= LD_phase + DECIM_LOG2'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_lin_decim.sv
// tb/tb_lin_decim.sv - directed self-checking bench for lin_decim (N = 4)
module tb_lin_decim;

  localparam int WIDTH      = 18;
  localparam int DECIM_LOG2 = 2;

  logic                  clock = 1'b0;
  logic                  reset = 1'b0;
  logic                  LD_in_en = 1'b0;
  logic                  LD_sync = 1'b0;
  logic [WIDTH-1:0]      LD_mR_in = '0;
  logic [WIDTH-1:0]      LD_pR_in = '0;
  logic [WIDTH-1:0]      LD_mR_out;
  logic [WIDTH-1:0]      LD_pR_out;
  logic                  LD_out_en;
  logic [DECIM_LOG2-1:0] LD_phase;

  int errors = 0;
  int checks = 0;
  int ma[4];
  int pa[4];

  lin_decim #(.WIDTH(WIDTH), .DECIM_LOG2(DECIM_LOG2)) dut (
    .clock     (clock),
    .reset     (reset),
    .LD_in_en  (LD_in_en),
    .LD_sync   (LD_sync),
    .LD_mR_in  (LD_mR_in),
    .LD_pR_in  (LD_pR_in),
    .LD_mR_out (LD_mR_out),
    .LD_pR_out (LD_pR_out),
    .LD_out_en (LD_out_en),
    .LD_phase  (LD_phase)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int mROut();
    return int'($signed(LD_mR_out));
  endfunction

  function automatic int pROut();
    return int'($signed(LD_pR_out));
  endfunction

  // One sample on one edge; back-to-back calls keep LD_in_en high with no gap.
  task automatic feed(input int m, input int p, input bit sync);
    LD_mR_in = m[WIDTH-1:0];
    LD_pR_in = p[WIDTH-1:0];
    LD_in_en = 1'b1;
    LD_sync  = sync;
    @(posedge clock);
    #1;
    LD_in_en = 1'b0;
    LD_sync  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic block4(input string tag, input int mExp, input int pExp);
    for (int i = 0; i < 4; i++) begin
      if (i != 0) check({tag, " strobe mid-block"}, int'(LD_out_en), 0);
      feed(ma[i], pa[i], 1'b0);
    end
    check({tag, " strobe"}, int'(LD_out_en), 1);
    check({tag, " mR"}, mROut(), mExp);
    check({tag, " pR"}, pROut(), pExp);
  endtask

  initial begin
    #12;
    check("reset mR", mROut(), 0);
    check("reset pR", pROut(), 0);
    check("reset strobe", int'(LD_out_en), 0);
    check("reset phase", int'(LD_phase), 0);
    reset = 1'b1;
    idle(1);

    ma = '{100, 200, 300, 400};
    pa = '{-100, -200, -300, -400};
    for (int i = 0; i < 4; i++) begin
      check("basic phase", int'(LD_phase), i);
      feed(ma[i], pa[i], 1'b0);
    end
    check("basic phase wrap", int'(LD_phase), 0);
    check("basic strobe", int'(LD_out_en), 1);
    check("basic mR", mROut(), 250);
    check("basic pR", pROut(), -250);
    idle(1);
    check("basic strobe width", int'(LD_out_en), 0);
    check("basic mR hold", mROut(), 250);

    ma = '{-1, -1, -1, -2};
    pa = '{1, 1, 1, 2};
    block4("round", -2, 1);

    ma = '{131071, 131071, 131071, 131071};
    pa = '{-131072, -131072, -131072, -131072};
    block4("extreme", 131071, -131072);

    for (int i = 0; i < 4; i++) begin
      feed(10 * (i + 1), -10 * (i + 1), 1'b0);
      if (i < 3) begin
        for (int g = 0; g < i * 2 + (i == 2 ? 1 : 0); g++) begin
          idle(1);
          check("gap strobe", int'(LD_out_en), 0);
          check("gap mR hold", mROut(), 131071);
        end
      end
    end
    check("gap strobe", int'(LD_out_en), 1);
    check("gap mR", mROut(), 25);
    check("gap pR", pROut(), -25);
    idle(5);
    check("gap tail strobe", int'(LD_out_en), 0);
    check("gap tail phase", int'(LD_phase), 0);

    feed(1, 1, 1'b0);
    feed(1, 1, 1'b0);
    check("pre-sync phase", int'(LD_phase), 2);
    feed(8, 8, 1'b1);
    check("sync phase", int'(LD_phase), 1);
    check("sync strobe", int'(LD_out_en), 0);
    check("sync mR hold", mROut(), 25);
    feed(8, 8, 1'b0);
    check("sync strobe 2", int'(LD_out_en), 0);
    feed(8, 8, 1'b0);
    check("sync strobe 3", int'(LD_out_en), 0);
    feed(8, 8, 1'b0);
    check("sync block strobe", int'(LD_out_en), 1);
    check("sync block mR", mROut(), 8);
    check("sync block pR", pROut(), 8);

    feed(5, 5, 1'b0);
    feed(5, 5, 1'b0);
    feed(5, 5, 1'b0);
    feed(9, 9, 1'b1);
    check("sync at last strobe", int'(LD_out_en), 0);
    check("sync at last phase", int'(LD_phase), 1);
    check("sync at last mR hold", mROut(), 8);

    LD_sync = 1'b1;
    idle(1);
    LD_sync = 1'b0;
    check("sync idle phase", int'(LD_phase), 0);
    check("sync idle strobe", int'(LD_out_en), 0);

    feed(3, 3, 1'b0);
    feed(3, 3, 1'b0);
    feed(3, 3, 1'b0);
    check("pre-reset phase", int'(LD_phase), 3);
    #2;
    reset = 1'b0;
    #1;
    check("async mR", mROut(), 0);
    check("async pR", pROut(), 0);
    check("async phase", int'(LD_phase), 0);
    check("async strobe", int'(LD_out_en), 0);
    #3;
    reset = 1'b1;
    idle(1);
    ma = '{7, 7, 7, 7};
    pa = '{7, 7, 7, 7};
    block4("post-reset", 7, 7);

    #2;
    reset = 1'b0;
    #1;
    check("async strobe pulse", int'(LD_out_en), 0);
    reset = 1'b1;
    idle(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
